// File: rtl/axis_read_data_queued.sv
// axis_read_data_queued
// AXI read-data sink: queues stream-length commands, splits each AXI beat
// into DATA_WIDTH words, trims the unused words of a stream's final beat and
// forwards the words on a valid/ready stream with a per-stream last flag.
module axis_read_data_queued #(
  parameter int BUF_AWIDTH     = 9,
  parameter int CFG_AWIDTH     = 2,
  parameter int CONFIG_DWIDTH  = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int DATA_WIDTH     = 32,
  parameter int MSB_FIRST      = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CONFIG_DWIDTH-1:0]  cfg_length,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [AXI_DATA_WIDTH-1:0] axi_rdata,
  input  logic [1:0]                axi_rresp,
  input  logic                      axi_rvalid,
  output logic                      axi_rready,
  output logic [DATA_WIDTH-1:0]     data,
  output logic                      valid,
  output logic                      last,
  input  logic                      ready,
  output logic                      cmd_done,
  output logic                      err,
  input  logic                      err_clr
);

  localparam int RATIO     = AXI_DATA_WIDTH / DATA_WIDTH;
  localparam int KW        = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int BUF_DEPTH = 1 << BUF_AWIDTH;
  localparam int CFG_DEPTH = 1 << CFG_AWIDTH;
  localparam int FW        = DATA_WIDTH + 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ACTIVE, S_DONE} state_t;

  state_t state_q, state_d;

  // Command queue
  logic [CONFIG_DWIDTH-1:0] cq_mem [CFG_DEPTH];
  logic [CFG_AWIDTH:0]      cq_wr_q, cq_wr_d, cq_rd_q, cq_rd_d;
  logic                     cq_empty, cq_full, cq_push, cq_pop;
  logic [CONFIG_DWIDTH-1:0] len_q;

  // Beat hold register and word split
  logic [AXI_DATA_WIDTH-1:0] hold_q;
  logic                      hold_vld_q, hold_vld_d;
  logic [KW-1:0]             k_q, k_d;
  logic [CONFIG_DWIDTH-1:0]  rem_q, rem_d;
  logic [DATA_WIDTH-1:0]     sub_word;
  logic                      k_last, push, push_last, beat_acc;

  // Data FIFO
  logic [FW-1:0]           buf_mem [BUF_DEPTH];
  logic [BUF_AWIDTH:0]     bf_wr_q, bf_wr_d, bf_rd_q, bf_rd_d;
  logic                    bf_empty, bf_full, bf_wr, bf_pop;
  logic [FW-1:0]           bf_head, push_word, out_word;

  // Output register and error flag
  logic                  valid_q, valid_d, last_q, last_d;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  out_load, bypass, err_q, err_d, err_set;

  assign cq_empty = (cq_wr_q == cq_rd_q);
  assign cq_full  = (cq_wr_q[CFG_AWIDTH] != cq_rd_q[CFG_AWIDTH]) &&
                    (cq_wr_q[CFG_AWIDTH-1:0] == cq_rd_q[CFG_AWIDTH-1:0]);
  assign cfg_ready = ~cq_full;
  assign cq_push   = cfg_valid & ~cq_full;
  assign cq_pop    = (state_q == S_IDLE) & ~cq_empty;
  assign cq_wr_d   = cq_wr_q + (CFG_AWIDTH+1)'(cq_push);
  assign cq_rd_d   = cq_rd_q + (CFG_AWIDTH+1)'(cq_pop);

  assign bf_empty = (bf_wr_q == bf_rd_q);
  assign bf_full  = (bf_wr_q[BUF_AWIDTH] != bf_rd_q[BUF_AWIDTH]) &&
                    (bf_wr_q[BUF_AWIDTH-1:0] == bf_rd_q[BUF_AWIDTH-1:0]);
  assign bf_head  = buf_mem[bf_rd_q[BUF_AWIDTH-1:0]];

  assign k_last    = (k_q == KW'(RATIO - 1));
  assign push      = (state_q == S_ACTIVE) & hold_vld_q & ~bf_full;
  assign push_last = push & (rem_q == CONFIG_DWIDTH'(1));
  assign beat_acc  = axi_rvalid & axi_rready;
  assign push_word = {(rem_q == CONFIG_DWIDTH'(1)), sub_word};

  // An empty FIFO lets a freshly pushed word go straight to the output.
  assign out_load = ~valid_q | ready;
  assign bf_pop   = ~bf_empty & out_load;
  assign bypass   = bf_empty & out_load & push;
  assign bf_wr    = push & ~bypass;
  assign out_word = bf_pop ? bf_head : push_word;
  assign bf_wr_d  = bf_wr_q + (BUF_AWIDTH+1)'(bf_wr);
  assign bf_rd_d  = bf_rd_q + (BUF_AWIDTH+1)'(bf_pop);

  assign err_set = beat_acc & (axi_rresp != 2'b00);

  assign data  = data_q;
  assign valid = valid_q;
  assign last  = last_q;
  assign err   = err_q;

  // Select sub-word k of the held beat
  always_comb begin
    sub_word = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (k_q == KW'(i)) begin
        sub_word = hold_q[((MSB_FIRST != 0) ? (RATIO - 1 - i) : i) * DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (!cq_empty) state_d = S_LOAD;
      S_LOAD:   state_d = (len_q == '0) ? S_DONE : S_ACTIVE;
      S_ACTIVE: if (push_last) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // FSM outputs; the final push never takes a new beat since it would be discarded
  always_comb begin
    axi_rready = 1'b0;
    cmd_done   = 1'b0;
    case (state_q)
      S_ACTIVE: axi_rready = ~hold_vld_q | (k_last & push & ~push_last);
      S_DONE:   cmd_done   = 1'b1;
      default:  ;
    endcase
  end

  // Next values for hold-valid, sub-word index and remaining-word count
  always_comb begin
    hold_vld_d = hold_vld_q;
    k_d        = k_q;
    rem_d      = rem_q;
    case (state_q)
      S_LOAD: begin
        rem_d      = len_q;
        hold_vld_d = 1'b0;
        k_d        = '0;
      end
      S_ACTIVE: begin
        if (push) begin
          rem_d = rem_q - CONFIG_DWIDTH'(1);
          if (push_last) begin
            hold_vld_d = 1'b0;
            k_d        = '0;
          end else if (k_last) begin
            hold_vld_d = beat_acc;
            k_d        = '0;
          end else begin
            k_d = k_q + KW'(1);
          end
        end else if (beat_acc) begin
          hold_vld_d = 1'b1;
          k_d        = '0;
        end
      end
      S_DONE: begin
        hold_vld_d = 1'b0;
        k_d        = '0;
      end
      default: ;
    endcase
  end

  // Next values for the output register flags and the sticky error
  always_comb begin
    valid_d = valid_q;
    last_d  = last_q;
    if (bf_pop || bypass) begin
      valid_d = 1'b1;
      last_d  = out_word[FW-1];
    end else if (ready) begin
      valid_d = 1'b0;
    end
    err_d = err_q;
    if (err_clr) err_d = 1'b0;
    if (err_set) err_d = 1'b1;
  end

  // Control registers: pointers, counters, flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cq_wr_q    <= '0;
      cq_rd_q    <= '0;
      bf_wr_q    <= '0;
      bf_rd_q    <= '0;
      hold_vld_q <= 1'b0;
      k_q        <= '0;
      rem_q      <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      cq_wr_q    <= cq_wr_d;
      cq_rd_q    <= cq_rd_d;
      bf_wr_q    <= bf_wr_d;
      bf_rd_q    <= bf_rd_d;
      hold_vld_q <= hold_vld_d;
      k_q        <= k_d;
      rem_q      <= rem_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      err_q      <= err_d;
    end
  end

  // Data storage: queue/FIFO memories, popped length, held beat, output word
  always_ff @(posedge clk) begin
    if (cq_push) cq_mem[cq_wr_q[CFG_AWIDTH-1:0]] <= cfg_length;
    if (cq_pop)  len_q <= cq_mem[cq_rd_q[CFG_AWIDTH-1:0]];
    if (beat_acc) hold_q <= axi_rdata;
    if (bf_wr)   buf_mem[bf_wr_q[BUF_AWIDTH-1:0]] <= push_word;
    if (bf_pop || bypass) data_q <= out_word[DATA_WIDTH-1:0];
  end

endmodule

// File: tb/tb_axis_read_data_queued.sv
// Directed bench for axis_read_data_queued (RATIO = 2, 8-word data FIFO).
module tb_axis_read_data_queued;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] cfg_length;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [63:0] axi_rdata;
  logic [1:0]  axi_rresp;
  logic        axi_rvalid;
  logic        axi_rready;
  logic [31:0] data;
  logic        valid;
  logic        last;
  logic        ready;
  logic        cmd_done;
  logic        err;
  logic        err_clr;

  int n_chk = 0;
  int n_err = 0;

  logic [63:0] bq[$];
  logic [1:0]  br[$];
  logic [32:0] got[$];
  logic [32:0] exp_q[$];
  logic        hs = 1'b0;
  int          ready_mode = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  logic        saw_err = 1'b0;
  logic        stall = 1'b0;
  logic [32:0] held = '0;

  always #5 clk = ~clk;

  axis_read_data_queued #(
    .BUF_AWIDTH(3), .CFG_AWIDTH(2), .CONFIG_DWIDTH(32),
    .AXI_DATA_WIDTH(64), .DATA_WIDTH(32), .MSB_FIRST(0)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_length(cfg_length), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
    .data(data), .valid(valid), .last(last), .ready(ready),
    .cmd_done(cmd_done), .err(err), .err_clr(err_clr)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_chk++;
    if (obs !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, want);
    end
  endtask

  task automatic beat(input logic [31:0] hi, input logic [31:0] lo, input logic [1:0] resp);
    bq.push_back({hi, lo});
    br.push_back(resp);
  endtask

  task automatic expw(input logic [31:0] w, input logic l);
    exp_q.push_back({l, w});
  endtask

  // Called at a negedge; returns at a negedge with cfg_valid low.
  task automatic send_cmd(input int len);
    int t = 0;
    cfg_length = len;
    cfg_valid  = 1'b1;
    #1;
    while (!cfg_ready && t < 200) begin
      @(negedge clk); #1; t++;
    end
    if (t >= 200) chk("cmd accept timeout", 0, 1);
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic check_got(input string tag, input int bound);
    int t = 0;
    while (got.size() < exp_q.size() && t < bound) begin
      @(negedge clk); t++;
    end
    repeat (8) @(negedge clk);
    chk({tag, " word count"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got.size()) chk($sformatf("%s word%0d", tag, i), got[i], exp_q[i]);
    got.delete();
    exp_q.delete();
  endtask

  // AXI beat source and downstream ready pattern
  initial begin
    axi_rvalid = 1'b0; axi_rdata = '0; axi_rresp = 2'b00; ready = 1'b1;
    forever begin
      @(negedge clk);
      if (hs && bq.size() > 0) begin bq.delete(0); br.delete(0); end
      cyc++;
      ready = (ready_mode == 0) ? 1'b1 : (ready_mode == 1) ? (cyc % 3 == 0) : 1'b0;
      if (bq.size() > 0) begin
        axi_rvalid = 1'b1; axi_rdata = bq[0]; axi_rresp = br[0];
      end else begin
        axi_rvalid = 1'b0;
      end
      #1 hs = axi_rvalid && axi_rready;
    end
  end

  // Output monitor: captures transfers, checks stability under backpressure
  initial begin
    forever begin
      @(negedge clk); #2;
      if (!rst_n) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          chk("stall valid held", valid, 1);
          chk("stall word held", {last, data}, held);
        end
        if (valid && ready) got.push_back({last, data});
        stall = valid && !ready;
        held  = {last, data};
        if (cmd_done) done_cnt++;
        if (err) saw_err = 1'b1;
      end
    end
  end

  initial begin
    rst_n = 1'b0; cfg_length = '0; cfg_valid = 1'b0; err_clr = 1'b0;
    #12;
    chk("rst valid", valid, 0);
    chk("rst last", last, 0);
    chk("rst axi_rready", axi_rready, 0);
    chk("rst cmd_done", cmd_done, 0);
    chk("rst err", err, 0);
    chk("rst cfg_ready", cfg_ready, 1);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // T1: exact-multiple stream
    beat(32'h2, 32'h1, 2'b00); beat(32'h4, 32'h3, 2'b00);
    expw(32'h1, 0); expw(32'h2, 0); expw(32'h3, 0); expw(32'h4, 1);
    done_cnt = 0;
    send_cmd(4);
    check_got("T1", 200);
    chk("T1 cmd_done pulses", done_cnt, 1);
    chk("T1 err clear", err, 0);

    // T2: odd length trims word 4; next stream uses a fresh beat
    beat(32'h2, 32'h1, 2'b00); beat(32'h4, 32'h3, 2'b00); beat(32'h6, 32'h5, 2'b00);
    expw(32'h1, 0); expw(32'h2, 0); expw(32'h3, 1); expw(32'h5, 1);
    done_cnt = 0;
    send_cmd(3);
    send_cmd(1);
    check_got("T2", 200);
    chk("T2 cmd_done pulses", done_cnt, 2);
    chk("T2 beats consumed", bq.size(), 0);

    // T3: zero-length commands interleaved
    beat(32'h8, 32'h7, 2'b00); beat(32'hA, 32'h9, 2'b00);
    expw(32'h7, 0); expw(32'h8, 1); expw(32'h9, 1);
    done_cnt = 0;
    send_cmd(0); send_cmd(2); send_cmd(0); send_cmd(1);
    check_got("T3", 200);
    chk("T3 cmd_done pulses", done_cnt, 4);

    // Command queue full: one command parked in ACTIVE, four queued
    done_cnt = 0;
    for (int i = 0; i < 5; i++) send_cmd(1);
    #1 chk("cq full cfg_ready", cfg_ready, 0);
    repeat (3) @(negedge clk);
    #1 chk("cq full cfg_ready held", cfg_ready, 0);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      beat(32'h50 + i, 32'h40 + i, 2'b00);
      expw(32'h40 + i, 1);
    end
    check_got("CQ", 300);
    chk("CQ cmd_done pulses", done_cnt, 5);
    chk("CQ cfg_ready back", cfg_ready, 1);

    // T4: fill the FIFO with ready low, then drain 1-in-3
    ready_mode = 2;
    for (int i = 0; i < 10; i++) beat(32'h101 + 2*i, 32'h100 + 2*i, 2'b00);
    for (int j = 0; j < 20; j++) expw(32'h100 + j, (j == 19));
    done_cnt = 0;
    send_cmd(20);
    repeat (40) @(negedge clk);
    #2;
    chk("T4 axi_rready low when full", axi_rready, 0);
    chk("T4 valid while stalled", valid, 1);
    chk("T4 head word stable", {last, data}, {1'b0, 32'h100});
    @(negedge clk);
    ready_mode = 1;
    check_got("T4", 600);
    chk("T4 cmd_done pulses", done_cnt, 1);
    ready_mode = 0;

    // T5: error response on beat 2; data still forwarded; sticky until cleared
    chk("T5 err before", err, 0);
    beat(32'h12, 32'h11, 2'b00); beat(32'h14, 32'h13, 2'b10); beat(32'h16, 32'h15, 2'b00);
    expw(32'h11, 0); expw(32'h12, 0); expw(32'h13, 0);
    expw(32'h14, 0); expw(32'h15, 0); expw(32'h16, 1);
    send_cmd(6);
    check_got("T5", 200);
    chk("T5 err set", err, 1);
    repeat (5) @(negedge clk);
    chk("T5 err sticky", err, 1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    #2 chk("T5 err cleared", err, 0);

    // T5b: set and clear together -> set wins for that cycle
    @(negedge clk);
    err_clr = 1'b1;
    saw_err = 1'b0;
    beat(32'h22, 32'h21, 2'b11);
    expw(32'h21, 0); expw(32'h22, 1);
    send_cmd(2);
    check_got("T5b", 200);
    chk("T5b set beats clear", saw_err, 1);
    chk("T5b err cleared after", err, 0);
    err_clr = 1'b0;

    // T6: reset mid-stream with buffered data and err set
    ready_mode = 2;
    beat(32'h2B, 32'h2A, 2'b00); beat(32'h2D, 32'h2C, 2'b01);
    beat(32'h2F, 32'h2E, 2'b00); beat(32'h31, 32'h30, 2'b00);
    send_cmd(8);
    repeat (20) @(negedge clk);
    #2;
    chk("T6 valid before reset", valid, 1);
    chk("T6 err before reset", err, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("T6 rst valid", valid, 0);
    chk("T6 rst axi_rready", axi_rready, 0);
    chk("T6 rst err", err, 0);
    chk("T6 rst last", last, 0);
    bq.delete(); br.delete(); got.delete(); exp_q.delete();
    hs = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ready_mode = 0;
    done_cnt = 0;
    @(negedge clk);
    chk("T6 valid after reset", valid, 0);
    beat(32'h32, 32'h31, 2'b00);
    expw(32'h31, 0); expw(32'h32, 1);
    send_cmd(2);
    check_got("T6", 200);
    chk("T6 cmd_done pulses", done_cnt, 1);
    chk("T6 err stays clear", err, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
